// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle of the data cache controller.
// slave = the controller, master = the pipeline/memory environment driving it.
interface dcache_ctrl_if;
    logic        cpu_rd_en;
    logic        cpu_wr_en;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic [3:0]  cpu_byte_en;
    logic [31:0] cpu_rd_data;
    logic        cache_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wr_data, cpu_byte_en,
        input  mem_ready, mem_rvalid, mem_rdata,
        output cpu_rd_data, cache_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wr_data, cpu_byte_en,
        output mem_ready, mem_rvalid, mem_rdata,
        input  cpu_rd_data, cache_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Hits complete in zero cycles; misses refill a whole line in word order.
module dcache_ctrl #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic         clk,
    input  logic         rst,
    dcache_ctrl_if.slave bus
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    logic [1:0]       state_q, state_d;
    logic [OFF_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [NUM_LINES];
    logic [TAG_W-1:0] tag_d  [NUM_LINES];
    logic [31:0]      data_q [NUM_LINES][WORDS_PER_LINE];
    logic [31:0]      data_d [NUM_LINES][WORDS_PER_LINE];

    logic [OFF_W-1:0] cpu_off_s;
    logic [IDX_W-1:0] cpu_idx_s;
    logic [TAG_W-1:0] cpu_tag_s;
    logic [IDX_W-1:0] fill_idx_s;
    logic [TAG_W-1:0] fill_tag_s;
    logic             hit_s;
    logic             is_store_s;
    logic             is_load_s;
    logic [31:0]      hit_word_s;
    logic             stall_s;
    logic [31:0]      rd_data_s;
    logic             unused_addr_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
            else       r[8*b +: 8] = old_w[8*b +: 8];
        end
        return r;
    endfunction

    assign cpu_off_s     = bus.cpu_addr[2 +: OFF_W];
    assign cpu_idx_s     = bus.cpu_addr[2+OFF_W +: IDX_W];
    assign cpu_tag_s     = bus.cpu_addr[31 -: TAG_W];
    assign fill_idx_s    = addr_q[2+OFF_W +: IDX_W];
    assign fill_tag_s    = addr_q[31 -: TAG_W];
    assign unused_addr_s = ^bus.cpu_addr[1:0];

    // Store wins when both requests are raised together.
    assign is_store_s = bus.cpu_wr_en;
    assign is_load_s  = bus.cpu_rd_en & ~bus.cpu_wr_en;
    assign hit_s      = valid_q[cpu_idx_s] && (tag_q[cpu_idx_s] == cpu_tag_s);
    assign hit_word_s = data_q[cpu_idx_s][cpu_off_s];

    // Next-state, line fill and store-hit merge.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        data_d     = data_q;
        case (state_q)
            S_IDLE: begin
                if (is_store_s) begin
                    state_d = S_WRITE;
                    addr_d  = {bus.cpu_addr[31:2], 2'b00};
                    wdata_d = bus.cpu_wr_data;
                    wstrb_d = bus.cpu_byte_en;
                    if (hit_s) begin
                        data_d[cpu_idx_s][cpu_off_s] =
                            merge_bytes(hit_word_s, bus.cpu_wr_data, bus.cpu_byte_en);
                    end else begin
                        data_d[cpu_idx_s][cpu_off_s] = hit_word_s;
                    end
                end else if (is_load_s && !hit_s) begin
                    state_d    = S_REFILL;
                    fill_cnt_d = '0;
                    addr_d     = {bus.cpu_addr[31:2+OFF_W], {(2+OFF_W){1'b0}}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REFILL: begin
                if (bus.mem_rvalid) begin
                    data_d[fill_idx_s][fill_cnt_q] = bus.mem_rdata;
                    if (fill_cnt_q == LAST_BEAT) begin
                        tag_d[fill_idx_s]   = fill_tag_s;
                        valid_d[fill_idx_s] = 1'b1;
                        fill_cnt_d          = '0;
                        state_d             = S_IDLE;
                    end else begin
                        fill_cnt_d = fill_cnt_q + OFF_W'(1);
                    end
                end else begin
                    fill_cnt_d = fill_cnt_q;
                end
            end
            S_WRITE: begin
                if (bus.mem_ready) state_d = S_IDLE;
                else               state_d = S_WRITE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pipeline freeze and load return; both forced quiet while in reset.
    always_comb begin
        stall_s   = 1'b0;
        rd_data_s = 32'd0;
        if (rst) begin
            stall_s   = 1'b0;
            rd_data_s = 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    stall_s = is_store_s | (is_load_s & ~hit_s);
                    if (is_load_s && hit_s) rd_data_s = hit_word_s;
                    else                    rd_data_s = 32'd0;
                end
                S_REFILL: stall_s = 1'b1;
                S_WRITE:  stall_s = ~bus.mem_ready;
                default:  stall_s = 1'b0;
            endcase
        end
    end

    // State and cache storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fill_cnt_q <= '0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            valid_q    <= '0;
            for (int l = 0; l < NUM_LINES; l++) begin
                tag_q[l] <= '0;
                for (int w = 0; w < WORDS_PER_LINE; w++) data_q[l][w] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
        end
    end

    assign bus.cache_stall = stall_s;
    assign bus.cpu_rd_data = rd_data_s;
    assign bus.mem_req     = ~rst & ((state_q == S_REFILL) | (state_q == S_WRITE));
    assign bus.mem_we      = ~rst & (state_q == S_WRITE);
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_wstrb   = wstrb_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a backing-memory model answers refills and
// writes, load results are queued at issue and compared when the stall drops.
module tb_dcache_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_ctrl_if bus();

    dcache_ctrl #(.NUM_LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] mem_model [int unsigned];
    logic [31:0] exp_q [$];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.cpu_rd_en   = 1'b0;
        bus.cpu_wr_en   = 1'b0;
        bus.cpu_addr    = 32'd0;
        bus.cpu_wr_data = 32'd0;
        bus.cpu_byte_en = 4'd0;
        bus.mem_ready   = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = 32'd0;
    endtask

    // One CPU access; the memory side is answered until the stall drops.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int gap, input int rdy_dly,
                          input int exp_cycles);
        int cycles = 0;
        int beat = 0;
        int gapc = 0;
        int wcnt = 0;
        logic done = 1'b0;
        logic seen = 1'b0;
        logic [31:0] req_addr = 32'd0;
        logic [31:0] req_wdata = 32'd0;
        logic [3:0]  req_wstrb = 4'd0;
        logic        req_we = 1'b0;
        logic [31:0] old_w;
        logic [31:0] exp_d;
        @(negedge clk);
        bus.cpu_rd_en   = rd;
        bus.cpu_wr_en   = wr;
        bus.cpu_addr    = addr;
        bus.cpu_wr_data = wdata;
        bus.cpu_byte_en = be;
        if (rd && !wr) exp_q.push_back(mem_rd({addr[31:2], 2'b00}));
        for (int i = 0; i < 80 && !done; i++) begin
            #1;
            if (!bus.cache_stall) begin
                done = 1'b1;
            end else begin
                if (bus.mem_req && !seen) begin
                    seen      = 1'b1;
                    req_addr  = bus.mem_addr;
                    req_we    = bus.mem_we;
                    req_wdata = bus.mem_wdata;
                    req_wstrb = bus.mem_wstrb;
                end
                if (bus.mem_req && !bus.mem_we) begin
                    if (gapc == gap) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = mem_rd(bus.mem_addr + 32'(beat * 4));
                        beat++;
                        gapc = 0;
                    end else begin
                        gapc++;
                    end
                end
                if (bus.mem_req && bus.mem_we) begin
                    if (wcnt == rdy_dly) begin
                        bus.mem_ready = 1'b1;
                        old_w = mem_rd({addr[31:2], 2'b00});
                        for (int b = 0; b < 4; b++)
                            if (be[b]) old_w[8*b +: 8] = wdata[8*b +: 8];
                        mem_model[{addr[31:2], 2'b00}] = old_w;
                        #1;
                        done = !bus.cache_stall;
                    end else begin
                        wcnt++;
                    end
                end
                if (!done) begin
                    @(negedge clk);
                    bus.mem_rvalid = 1'b0;
                    bus.mem_ready  = 1'b0;
                    cycles++;
                end
            end
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_stall_cycles"}, 32'(cycles), 32'(exp_cycles));
        if (rd && !wr) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            chk({tag, "_rdata"}, bus.cpu_rd_data, exp_d);
        end
        if (exp_cycles > 0) begin
            chk({tag, "_mem_addr"}, req_addr,
                wr ? {addr[31:2], 2'b00} : {addr[31:4], 4'b0000});
            chk({tag, "_mem_we"}, {31'd0, req_we}, {31'd0, wr});
            if (wr) begin
                chk({tag, "_mem_wdata"}, req_wdata, wdata);
                chk({tag, "_mem_wstrb"}, {28'd0, req_wstrb}, {28'd0, be});
            end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        chk({tag, "_req_after"}, {31'd0, bus.mem_req}, 32'd0);
    endtask

    initial begin
        mem_model[32'h100] = 32'h0000_00A0;
        mem_model[32'h104] = 32'h0000_00A1;
        mem_model[32'h108] = 32'h0000_00A2;
        mem_model[32'h10C] = 32'h0000_00A3;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, bus.cache_stall}, 32'd0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        chk("rst_rd_data", bus.cpu_rd_data, 32'd0);
        rst = 1'b0;

        // Refill, hit, store hit with slow ready, store miss without allocate.
        access("ld100_miss", 1'b1, 1'b0, 32'h100, 32'd0, 4'd0, 0, 0, 5);
        access("ld10C_hit", 1'b1, 1'b0, 32'h10C, 32'd0, 4'd0, 0, 0, 0);
        access("st104_hit", 1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0011, 0, 3, 4);
        access("ld104_hit", 1'b1, 1'b0, 32'h104, 32'd0, 4'd0, 0, 0, 0);
        chk("merged_word", mem_rd(32'h104), 32'h0000_BEEF);
        access("st2000_miss", 1'b0, 1'b1, 32'h2000, 32'h1234_5678, 4'b1111, 0, 0, 1);
        access("ld2000_miss", 1'b1, 1'b0, 32'h2000, 32'd0, 4'd0, 0, 0, 5);

        // Same index, different tags evict each other.
        access("ld100_conf", 1'b1, 1'b0, 32'h100, 32'd0, 4'd0, 0, 0, 5);
        access("ld500_conf", 1'b1, 1'b0, 32'h500, 32'd0, 4'd0, 0, 0, 5);
        access("ld100_again", 1'b1, 1'b0, 32'h100, 32'd0, 4'd0, 0, 0, 5);

        // Stray beats in IDLE must not disturb the cached line.
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0_BAD0;
        repeat (2) @(negedge clk);
        #1;
        chk("stray_mem_req", {31'd0, bus.mem_req}, 32'd0);
        bus.mem_rvalid = 1'b0;
        access("ld108_hit", 1'b1, 1'b0, 32'h108, 32'd0, 4'd0, 0, 0, 0);

        // Both requests high: treated as a store.
        access("both_st108", 1'b1, 1'b1, 32'h108, 32'hCAFE_F00D, 4'b1100, 0, 1, 2);
        access("ld108_merged", 1'b1, 1'b0, 32'h108, 32'd0, 4'd0, 0, 0, 0);

        // Gapped refill keeps word order.
        access("ld640_gap", 1'b1, 1'b0, 32'h640, 32'd0, 4'd0, 2, 0, 13);
        access("ld644_hit", 1'b1, 1'b0, 32'h644, 32'd0, 4'd0, 0, 0, 0);
        access("ld64C_hit", 1'b1, 1'b0, 32'h64C, 32'd0, 4'd0, 0, 0, 0);

        // Reset in the middle of a refill.
        @(negedge clk);
        bus.cpu_rd_en = 1'b1;
        bus.cpu_addr  = 32'h300;
        #1;
        chk("r6_miss_stall", {31'd0, bus.cache_stall}, 32'd1);
        @(negedge clk);
        #1;
        chk("r6_req", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_1111;
        @(negedge clk);
        bus.mem_rdata  = 32'h2222_2222;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("r6_rst_stall", {31'd0, bus.cache_stall}, 32'd0);
        chk("r6_rst_rdata", bus.cpu_rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.cpu_rd_en = 1'b0;
        #1;
        chk("r6_req_after_rst", {31'd0, bus.mem_req}, 32'd0);
        chk("r6_stall_after_rst", {31'd0, bus.cache_stall}, 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h3333_3333;
        repeat (2) @(negedge clk);
        bus.mem_rvalid = 1'b0;
        access("ld300_after_rst", 1'b1, 1'b0, 32'h300, 32'd0, 4'd0, 0, 0, 5);
        access("ld304_after_rst", 1'b1, 1'b0, 32'h304, 32'd0, 4'd0, 0, 0, 0);
        access("ld640_after_rst", 1'b1, 1'b0, 32'h640, 32'd0, 4'd0, 0, 0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
